// File: rtl/move_arbiter.sv
// -----------------------------------------------------------------------------
// move_arbiter
//
// Collects player key presses and gravity ticks into a set of pending
// requests and offers them one at a time to the board logic through a
// valid/ack handshake. Priority: GRAVITY > ROTATE > LEFT > RIGHT > DOWN.
//
// Ports
//   clk         system clock (50 MHz)
//   rst_n       asynchronous, active-low reset
//   rotate_lvl  sampled key level, active-high
//   left_lvl    sampled key level, active-high
//   right_lvl   sampled key level, active-high
//   down_lvl    sampled key level, active-high
//   tick        one-cycle gravity pulse
//   run         game active; low flushes all pending work and forces IDLE
//   cmd_valid   a command is being offered
//   cmd_code    0 NONE, 1 ROTATE, 2 LEFT, 3 RIGHT, 4 DOWN, 5 GRAVITY
//   cmd_ack     board logic accepted the offered command
//   grav_miss   one-cycle pulse when a gravity tick merges into one pending
//
// Parameters
//   REPEAT_DLY  clk cycles a key must be held before its first auto-repeat
//   REPEAT_PER  clk cycles between subsequent auto-repeats
//
// Build option
//   MOVE_ARBITER_AUTOREPEAT_EN  when defined, LEFT, RIGHT and DOWN each get a
//   24-bit hold counter that re-requests the command while the key stays
//   down. When undefined, only press edges create requests.
// -----------------------------------------------------------------------------
module move_arbiter #(
  parameter logic [23:0] REPEAT_DLY = 24'd10_000_000,
  parameter logic [23:0] REPEAT_PER = 24'd2_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rotate_lvl,
  input  logic       left_lvl,
  input  logic       right_lvl,
  input  logic       down_lvl,
  input  logic       tick,
  input  logic       run,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  input  logic       cmd_ack,
  output logic       grav_miss
);

  typedef enum logic [2:0] {
    CMD_NONE    = 3'd0,
    CMD_ROTATE  = 3'd1,
    CMD_LEFT    = 3'd2,
    CMD_RIGHT   = 3'd3,
    CMD_DOWN    = 3'd4,
    CMD_GRAVITY = 3'd5
  } cmd_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  // Bit positions inside the packed key vectors.
  localparam int K_ROT   = 0;
  localparam int K_LEFT  = 1;
  localparam int K_RIGHT = 2;
  localparam int K_DOWN  = 3;

  logic [3:0] key_lvl;
  logic [3:0] prev_q, prev_d;
  logic [3:0] arm_q, arm_d;
  logic [3:0] key_press;
  logic [3:1] key_rep;
  logic       conflict;

  logic [5:1] pend_q, pend_d;
  logic [5:1] event_vec;
  logic [5:1] grant_clr;
  logic       acked;
  cmd_e       prio_code;

  logic       grav_miss_q, grav_miss_d;
  state_e     state_q, state_d;
  logic       cmd_valid_q, cmd_valid_d;
  cmd_e       cmd_code_q, cmd_code_d;

  assign key_lvl = {down_lvl, right_lvl, left_lvl, rotate_lvl};

  // ---------------------------------------------------------------------------
  // Edge detection. A key is only armed once it has been seen low, so a key
  // that is already held when reset releases never counts as a press.
  // ---------------------------------------------------------------------------
  always_comb begin
    prev_d    = key_lvl;
    arm_d     = arm_q | ~key_lvl;
    key_press = key_lvl & ~prev_q & arm_q;
  end

  // Holding LEFT and RIGHT together cancels both until one is released.
  assign conflict = run & left_lvl & right_lvl;

`ifdef MOVE_ARBITER_AUTOREPEAT_EN
  // ---------------------------------------------------------------------------
  // Auto-repeat: index 0 LEFT, 1 RIGHT, 2 DOWN. The counter runs from 0 in the
  // press cycle; hitting REPEAT_DLY fires, then it reloads so the next hit is
  // REPEAT_PER cycles later. Any break in eligibility restarts it at 0.
  // ---------------------------------------------------------------------------
  localparam logic [23:0] REPEAT_RELOAD = REPEAT_DLY - REPEAT_PER + 24'd1;

  logic [23:0] hold_cnt_q [3];
  logic [23:0] hold_cnt_d [3];
  logic [2:0]  hold_en;
  logic [2:0]  rep_fire;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      hold_en[i]  = run & key_lvl[i+1] & arm_q[i+1] & ~(conflict & (i != 2));
      rep_fire[i] = hold_en[i] & (hold_cnt_q[i] == REPEAT_DLY);
      if (!hold_en[i]) begin
        hold_cnt_d[i] = '0;
      end else if (rep_fire[i]) begin
        hold_cnt_d[i] = REPEAT_RELOAD;
      end else begin
        hold_cnt_d[i] = hold_cnt_q[i] + 24'd1;
      end
    end
  end

  // NOTE: these counters are control state (a stale count would fire a
  // spurious repeat), so unlike a data RAM they must be reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) hold_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) hold_cnt_q[i] <= hold_cnt_d[i];
    end
  end

  assign key_rep = rep_fire;
`else
  assign key_rep = 3'b000;

  // The timing parameters stay on the interface so both builds share one
  // instantiation; this empty scope is their only reference here.
  if ((REPEAT_DLY | REPEAT_PER) == 24'd0) begin : g_repeat_cfg_zero
  end
`endif

  // ---------------------------------------------------------------------------
  // Request events for this cycle. ROTATE only ever comes from a press edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    event_vec = '0;
    if (run) begin
      event_vec[CMD_ROTATE]  = key_press[K_ROT];
      event_vec[CMD_LEFT]    = key_press[K_LEFT]  | key_rep[K_LEFT];
      event_vec[CMD_RIGHT]   = key_press[K_RIGHT] | key_rep[K_RIGHT];
      event_vec[CMD_DOWN]    = key_press[K_DOWN]  | key_rep[K_DOWN];
      event_vec[CMD_GRAVITY] = tick;
    end
  end

  assign acked = (state_q == ST_ISSUE) & cmd_ack;

  // One-hot of the command being retired by this cycle's ack.
  always_comb begin
    grant_clr = '0;
    for (int i = 1; i <= 5; i++) begin
      grant_clr[i] = acked & (int'(cmd_code_q) == i);
    end
  end

  // Set wins over clear, so an event coinciding with the ack of the same
  // command survives as a fresh request.
  always_comb begin
    pend_d = (pend_q & ~grant_clr) | event_vec;
    if (conflict) begin
      pend_d[CMD_LEFT]  = 1'b0;
      pend_d[CMD_RIGHT] = 1'b0;
    end
    if (!run) begin
      pend_d = '0;
    end
  end

  // A tick lands on an already-pending gravity request that is not being
  // retired this cycle: it is absorbed and reported.
  assign grav_miss_d = run & tick & pend_q[CMD_GRAVITY] & ~grant_clr[CMD_GRAVITY];

  always_comb begin
    prio_code = CMD_NONE;
    if (pend_q[CMD_GRAVITY]) begin
      prio_code = CMD_GRAVITY;
    end else if (pend_q[CMD_ROTATE]) begin
      prio_code = CMD_ROTATE;
    end else if (pend_q[CMD_LEFT]) begin
      prio_code = CMD_LEFT;
    end else if (pend_q[CMD_RIGHT]) begin
      prio_code = CMD_RIGHT;
    end else if (pend_q[CMD_DOWN]) begin
      prio_code = CMD_DOWN;
    end
  end

  // NOTE: all state flops use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= '0;
      arm_q       <= '0;
      pend_q      <= '0;
      grav_miss_q <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      arm_q       <= arm_d;
      pend_q      <= pend_d;
      grav_miss_q <= grav_miss_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM. The code is latched on entry to ISSUE and held until the ack,
  // so the board never sees the offer change under it. Returning through IDLE
  // spaces consecutive commands at least two cycles apart.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_code_d  = cmd_code_q;
    if (!run) begin
      state_d     = ST_IDLE;
      cmd_valid_d = 1'b0;
      cmd_code_d  = CMD_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|pend_q) begin
            state_d     = ST_ISSUE;
            cmd_valid_d = 1'b1;
            cmd_code_d  = prio_code;
          end
        end
        ST_ISSUE: begin
          if (cmd_ack) begin
            state_d     = ST_IDLE;
            cmd_valid_d = 1'b0;
            cmd_code_d  = CMD_NONE;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          cmd_valid_d = 1'b0;
          cmd_code_d  = CMD_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= CMD_NONE;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign grav_miss = grav_miss_q;

endmodule
